// File: rtl/lut_config_loader.sv
// -----------------------------------------------------------------------------
// lut_config_loader
//
// Feeds the LUT configuration latches from a serial bitstream. Bits arrive
// LSB-first over a valid/ready handshake and are assembled into MEM_SIZE-bit
// words. Each finished word is presented on the shared config_out bus while
// the matching one-hot cen_out bit pulses for one cycle. LUTs are loaded in
// order 0..NUM_LUTS-1, then done pulses once for the whole frame.
//
// Ports
//   cclk        in   1         config clock, all state on the rising edge
//   crst        in   1         synchronous active-high reset
//   start       in   1         begin a frame (only honoured in IDLE)
//   bit_in      in   1         serial config bit
//   bit_valid   in   1         bit_in is valid
//   bit_ready   out  1         a bit is accepted this cycle when valid
//   config_out  out  MEM_SIZE  deserialized word (shared LUT config bus)
//   cen_out     out  NUM_LUTS  one-hot per-LUT config enable, 1-cycle pulse
//   busy        out  1         frame in progress (SHIFT/LOAD/DONE)
//   done        out  1         1-cycle pulse when the frame is complete
// -----------------------------------------------------------------------------
module lut_config_loader #(
    parameter int INPUTS   = 4,
    parameter int MEM_SIZE = 32'd1 << INPUTS,
    parameter int NUM_LUTS = 4
) (
    input  logic                cclk,
    input  logic                crst,
    input  logic                start,
    input  logic                bit_in,
    input  logic                bit_valid,
    output logic                bit_ready,
    output logic [MEM_SIZE-1:0] config_out,
    output logic [NUM_LUTS-1:0] cen_out,
    output logic                busy,
    output logic                done
);

    localparam int BW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam int LW = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;

    localparam logic [BW-1:0]       BIT_LAST = BW'(MEM_SIZE - 1);
    localparam logic [LW-1:0]       LUT_LAST = LW'(NUM_LUTS - 1);
    localparam logic [MEM_SIZE-1:0] MEM_ONE  = MEM_SIZE'(1'b1);
    localparam logic [NUM_LUTS-1:0] LUT_ONE  = NUM_LUTS'(1'b1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LOAD  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e              state_q,     state_d;
    logic [BW-1:0]       bit_cnt_q,   bit_cnt_d;
    logic [LW-1:0]       lut_idx_q,   lut_idx_d;
    logic [MEM_SIZE-1:0] config_q,    config_d;
    logic [NUM_LUTS-1:0] cen_q,       cen_d;
    logic                bit_ready_q, bit_ready_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;

    logic                xfer_s;
    logic [MEM_SIZE-1:0] bit_mask_s;

    // A transfer needs the registered ready that the source actually saw.
    assign xfer_s     = (state_q == S_SHIFT) && bit_ready_q && bit_valid;
    assign bit_mask_s = MEM_ONE << bit_cnt_q;

    // Next-state, counter and word-assembly logic.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        lut_idx_d = lut_idx_q;
        config_d  = config_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_SHIFT;
                    bit_cnt_d = '0;
                    lut_idx_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (xfer_s) begin
                    // k-th accepted bit of the word lands in bit k.
                    config_d = (config_q & ~bit_mask_s) | ({MEM_SIZE{bit_in}} & bit_mask_s);
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d   = S_LOAD;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1'b1);
                    end
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_LOAD: begin
                if (lut_idx_q == LUT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    lut_idx_d = lut_idx_q + LW'(1'b1);
                    state_d   = S_SHIFT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output lookahead: outputs are decoded from the next state so the
    // registered versions line up with the state they describe.
    always_comb begin
        // The first SHIFT cycle after start is an arming cycle: ready rises
        // one cycle later, so a frame always begins with ready low.
        bit_ready_d = (state_d == S_SHIFT) && (state_q != S_IDLE);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        if (state_d == S_LOAD) begin
            cen_d = LUT_ONE << lut_idx_q;
        end else begin
            cen_d = '0;
        end
    end

    // State, counters and registered outputs; reset overrides everything.
    always_ff @(posedge cclk) begin
        if (crst) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            lut_idx_q   <= '0;
            config_q    <= '0;
            cen_q       <= '0;
            bit_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            lut_idx_q   <= lut_idx_d;
            config_q    <= config_d;
            cen_q       <= cen_d;
            bit_ready_q <= bit_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bit_ready  = bit_ready_q;
    assign config_out = config_q;
    assign cen_out    = cen_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_lut_config_loader.sv
// -----------------------------------------------------------------------------
// tb_lut_config_loader
//
// Directed bench for lut_config_loader. dut_a uses the default geometry
// (16-bit words, 4 LUTs); dut_b uses 4-bit words and a single LUT.
// -----------------------------------------------------------------------------
module tb_lut_config_loader;

    logic        cclk;
    logic        a_crst, a_start, a_bit_in, a_bit_valid;
    logic        a_bit_ready, a_busy, a_done;
    logic [15:0] a_config_out;
    logic [3:0]  a_cen_out;

    logic        b_crst, b_start, b_bit_in, b_bit_valid;
    logic        b_bit_ready, b_busy, b_done;
    logic [3:0]  b_config_out;
    logic [0:0]  b_cen_out;

    int          n_cmp;
    int          n_mis;
    logic [15:0] words [4];

    lut_config_loader dut_a (
        .cclk       (cclk),
        .crst       (a_crst),
        .start      (a_start),
        .bit_in     (a_bit_in),
        .bit_valid  (a_bit_valid),
        .bit_ready  (a_bit_ready),
        .config_out (a_config_out),
        .cen_out    (a_cen_out),
        .busy       (a_busy),
        .done       (a_done)
    );

    lut_config_loader #(.INPUTS(2), .NUM_LUTS(1)) dut_b (
        .cclk       (cclk),
        .crst       (b_crst),
        .start      (b_start),
        .bit_in     (b_bit_in),
        .bit_valid  (b_bit_valid),
        .bit_ready  (b_bit_ready),
        .config_out (b_config_out),
        .cen_out    (b_cen_out),
        .busy       (b_busy),
        .done       (b_done)
    );

    // Free-running 10-unit clock.
    initial begin
        cclk = 1'b0;
        forever #5 cclk = ~cclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 unit after the rising edge.
    task automatic step();
        @(posedge cclk);
        #1;
    endtask

    // Runs one frame on dut_a with the contents of words[]. Cycle numbers
    // count edges after the edge that sampled start (that edge is 0).
    //   stall      : pseudo-random bit_valid, bit_cnt tracked every cycle
    //   poke_start : pulse start mid-SHIFT and during the DONE cycle
    //   abort_n    : return as soon as this many bits were accepted (0 = never)
    task automatic run_frame(input bit stall, input bit poke_start, input int abort_n);
        int w, b, n, cyc, lut;
        bit xfer, fin;
        w = 0; b = 0; n = 0; lut = 0; fin = 1'b0;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        cyc = 0;
        chk("start_busy", a_busy, 1'b1);
        chk("arm_ready", a_bit_ready, 1'b0);
        for (int k = 0; k < 600 && !fin; k++) begin
            a_bit_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            a_bit_in    = (w < 4) ? words[w][b] : 1'b0;
            a_start     = poke_start && (cyc == 5);
            xfer        = a_bit_ready && a_bit_valid;
            step();
            cyc++;
            a_start = 1'b0;
            if (xfer) begin
                n++;
                b++;
                if (b == 16) begin
                    b = 0;
                    w++;
                end
            end
            if (stall) chk("bit_cnt", dut_a.bit_cnt_q, b);
            if (abort_n != 0 && n == abort_n) begin
                fin = 1'b1;
            end else if (a_cen_out != 4'd0) begin
                chk("cen_onehot", a_cen_out, 32'd1 << lut);
                chk("cen_word", a_config_out, (lut < 4) ? words[lut] : 16'd0);
                chk("ready_in_load", a_bit_ready, 1'b0);
                if (!stall) chk("cen_cycle", cyc, 17 * (lut + 1));
                lut++;
            end else if (a_done) begin
                chk("done_luts", lut, 4);
                chk("ready_in_done", a_bit_ready, 1'b0);
                chk("busy_in_done", a_busy, 1'b1);
                if (!stall) chk("done_cycle", cyc, 69);
                fin = 1'b1;
            end
        end
        if (!fin) chk("frame_timeout", 1'b0, 1'b1);
        if (fin && abort_n == 0) begin
            // start during the DONE cycle must not restart the frame.
            a_start = poke_start;
            step();
            a_start = 1'b0;
            chk("idle_after_done", {a_busy, a_done, a_bit_ready}, 3'b000);
            step();
            chk("still_idle", {a_busy, a_cen_out}, 5'd0);
        end
    endtask

    initial begin
        int   nb, cyc;
        bit   xfer, fin;
        logic [3:0] pat;
        n_cmp = 0;
        n_mis = 0;
        a_crst = 1'b1; a_start = 1'b0; a_bit_in = 1'b0; a_bit_valid = 1'b0;
        b_crst = 1'b1; b_start = 1'b0; b_bit_in = 1'b0; b_bit_valid = 1'b0;

        // 1: reset with random inputs.
        for (int i = 0; i < 2; i++) begin
            a_start     = 1'($urandom_range(0, 1));
            a_bit_in    = 1'($urandom_range(0, 1));
            a_bit_valid = 1'($urandom_range(0, 1));
            step();
            chk("rst_outputs", {a_bit_ready, a_busy, a_done, a_cen_out}, 7'd0);
            chk("rst_config", a_config_out, 16'd0);
            chk("rst_b", {b_bit_ready, b_busy, b_done, b_cen_out, b_config_out}, 8'd0);
        end
        a_crst = 1'b0; b_crst = 1'b0;
        a_start = 1'b0; a_bit_valid = 1'b0;
        step();
        chk("idle_no_start", {a_busy, a_bit_ready}, 2'b00);

        // 2: full frame, bit_valid held high.
        words[0] = 16'hA5C3; words[1] = 16'h0001; words[2] = 16'h8000; words[3] = 16'hFFFF;
        run_frame(1'b0, 1'b0, 0);

        // 3: stalled frame.
        words[0] = 16'h1234; words[1] = 16'h5678; words[2] = 16'h9ABC; words[3] = 16'hDEF0;
        run_frame(1'b1, 1'b0, 0);

        // 4: start pulses while busy.
        words[0] = 16'h0F0F; words[1] = 16'h3C3C; words[2] = 16'h6996; words[3] = 16'hC001;
        run_frame(1'b0, 1'b1, 0);

        // 5: reset after LUT0 and 7 bits of LUT1, then a clean frame.
        words[0] = 16'hBEEF; words[1] = 16'hCAFE; words[2] = 16'h1111; words[3] = 16'h2222;
        run_frame(1'b0, 1'b0, 23);
        a_crst = 1'b1;
        step();
        a_crst = 1'b0;
        chk("abort_outputs", {a_bit_ready, a_busy, a_done, a_cen_out}, 7'd0);
        chk("abort_config", a_config_out, 16'd0);
        a_bit_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a_bit_in = 1'($urandom_range(0, 1));
            step();
            chk("abort_quiet", {a_busy, a_cen_out}, 5'd0);
        end
        words[0] = 16'h8001; words[1] = 16'h4002; words[2] = 16'h2004; words[3] = 16'h1008;
        run_frame(1'b0, 1'b0, 0);

        // 6: single 4-bit LUT on dut_b.
        pat = 4'b1010;
        nb  = 0;
        fin = 1'b0;
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        cyc = 0;
        b_bit_valid = 1'b1;
        for (int k = 0; k < 20 && !fin; k++) begin
            b_bit_in = (nb < 4) ? pat[nb] : 1'b0;
            xfer = b_bit_ready && b_bit_valid;
            step();
            cyc++;
            if (xfer) nb++;
            if (b_cen_out != 1'b0) begin
                chk("b_cen", b_cen_out, 1'b1);
                chk("b_word", b_config_out, 4'hA);
                chk("b_ready_load", b_bit_ready, 1'b0);
                chk("b_cen_cycle", cyc, 5);
            end else if (b_done) begin
                chk("b_done_cycle", cyc, 6);
                chk("b_ready_done", b_bit_ready, 1'b0);
                chk("b_busy_done", b_busy, 1'b1);
                chk("b_word_hold", b_config_out, 4'hA);
                fin = 1'b1;
            end
        end
        if (!fin) chk("b_timeout", 1'b0, 1'b1);
        step();
        chk("b_idle", {b_busy, b_done, b_bit_ready}, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
